// File: rtl/crypto_harness_pkg.sv
// Shared types and constants for the crypto core test harness.
package crypto_harness_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // x^64 + x^63 + x^61 + x^60 + 1, maximal length for a 64-bit Fibonacci LFSR
  localparam logic [63:0] LFSR_TAPS    = 64'hD800_0000_0000_0000;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/crypto_test_harness_sig_misr.sv
// Signature register: folds each captured core result to SIG_W bits and
// mixes it into a rotate-left-by-one accumulator.
module sig_misr #(
  parameter int DATA_W = 64,
  parameter int SIG_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              capture,
  input  logic [DATA_W-1:0] data,
  output logic [SIG_W-1:0]  signature
);

  localparam int SLICES = DATA_W / SIG_W;

  logic [SIG_W-1:0] fold;

  always_comb begin
    fold = '0;
    for (int i = 0; i < SLICES; i++) begin
      fold = fold ^ data[i*SIG_W +: SIG_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      signature <= '0;
    end else if (capture) begin
      signature <= {signature[SIG_W-2:0], signature[SIG_W-1]} ^ fold;
    end
  end

endmodule

// File: rtl/crypto_test_harness.sv
// Self-test harness: streams NUM_VEC LFSR vectors and derived keys into a
// fixed-latency crypto core and compresses the results into a signature.
module crypto_test_harness
  import crypto_harness_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int KEY_W    = 56,
  parameter int CORE_LAT = 48,
  parameter int NUM_VEC  = 1024,
  parameter int SIG_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       seed,
  input  logic              mode,
  output logic [DATA_W-1:0] core_in,
  output logic [KEY_W-1:0]  core_key1,
  output logic [KEY_W-1:0]  core_key2,
  output logic [KEY_W-1:0]  core_key3,
  output logic              core_decrypt,
  input  logic [DATA_W-1:0] core_out,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = $clog2(NUM_VEC + 1);

  // Protocol: start is level-sampled in IDLE/DONE only; busy marks an active
  // run; done rises with the final capture and holds the signature until the
  // next launch or reset. No backpressure exists on the core interface.

  state_t              state;
  logic [DATA_W-1:0]   lfsr;
  logic [DATA_W-1:0]   lfsr_next;
  logic [DATA_W-1:0]   seed_rep;
  logic [15:0]         seed_eff;
  logic [CNT_W-1:0]    issue_cnt;
  logic [CNT_W-1:0]    cap_cnt;
  logic                issue_v;
  logic [CORE_LAT-1:0] vpipe;
  logic                launch;
  logic                capture;
  logic                last_capture;

  assign seed_eff     = (seed == 16'd0) ? DEFAULT_SEED : seed;
  assign launch       = ((state == IDLE) || (state == DONE)) && start;
  // vpipe's last stage lines up with core_out for the vector that issue_v
  // accompanied on core_in, so it is exactly the capture strobe.
  assign capture      = vpipe[CORE_LAT-1];
  assign last_capture = capture && (cap_cnt == CNT_W'(NUM_VEC - 1));
  assign state_dbg    = state;

  always_comb begin
    seed_rep = '0;
    for (int i = 0; i < DATA_W; i++) begin
      seed_rep[i] = seed_eff[i % 16];
    end
    lfsr_next = {lfsr[DATA_W-2:0], ^(lfsr & LFSR_TAPS[DATA_W-1:0])};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lfsr         <= '0;
      core_in      <= '0;
      core_key1    <= '0;
      core_key2    <= '0;
      core_key3    <= '0;
      core_decrypt <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      issue_cnt    <= '0;
      cap_cnt      <= '0;
      issue_v      <= 1'b0;
      vpipe        <= '0;
    end else begin
      issue_v  <= (state == RUN);
      vpipe[0] <= issue_v;
      for (int i = 1; i < CORE_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
      end
      if (capture) begin
        cap_cnt <= cap_cnt + 1'b1;
      end
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            state        <= RUN;
            lfsr         <= seed_rep;
            core_decrypt <= mode;
            issue_cnt    <= '0;
            cap_cnt      <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
          end
        end
        RUN: begin
          core_in   <= lfsr;
          core_key1 <= lfsr[DATA_W-1 -: KEY_W];
          core_key2 <= lfsr[DATA_W-4 -: KEY_W];
          core_key3 <= lfsr[KEY_W-1:0];
          lfsr      <= lfsr_next;
          issue_cnt <= issue_cnt + 1'b1;
          if (issue_cnt == CNT_W'(NUM_VEC - 1)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_capture) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sig_misr #(
    .DATA_W(DATA_W),
    .SIG_W (SIG_W)
  ) u_sig_misr (
    .clk      (clk),
    .reset    (reset),
    .clear    (launch),
    .capture  (capture),
    .data     (core_out),
    .signature(signature)
  );

endmodule

// File: doc/crypto_test_harness.md
CRYPTO_TEST_HARNESS -- requirements
Module: crypto_test_harness

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  DATA_W  64  core data width
  KEY_W  56  per-key width; SHALL satisfy KEY_W <= DATA_W-8
  CORE_LAT  48  fixed core pipeline latency in cycles, >=1
  NUM_VEC  1024  vectors per run, >=1
  SIG_W  16  signature width; DATA_W % SIG_W SHALL be 0
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  sole clock, rising edge
  reset  in  1  synchronous, active-high
  start  in  1  launch request, level-sampled
  seed  in  16  LFSR seed
  mode  in  1  0 encrypt, 1 decrypt
  core_in  out  DATA_W  vector to core
  core_key1, core_key2, core_key3  out  KEY_W each  keys to core
  core_decrypt  out  1  direction to core
  core_out  in  DATA_W  core result
  busy  out  1  run in progress
  done  out  1  run complete, signature valid
  signature  out  SIG_W  compressed result
REQ-003 One clock; reset is synchronous and active-high.

Function
REQ-004 FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE->RUN on start.
  - RUN->DRAIN after the NUM_VEC-th vector issues.
  - DRAIN->DONE when the NUM_VEC-th result is captured.
  - DONE->RUN on start.
REQ-005 Launch from IDLE or DONE: load LFSR with {seed,seed,seed,seed} truncated/replicated to DATA_W; seed==0 SHALL be replaced by 16'hACE1. Latch mode into core_decrypt. Clear signature, issue count, capture count.
REQ-006 LFSR: DATA_W-bit Fibonacci, maximal-length taps from package; advances once per RUN cycle.
REQ-007 RUN cycle k (k=0..NUM_VEC-1): core_in = LFSR state; core_key1 = state[DATA_W-1 -: KEY_W]; core_key2 = state[DATA_W-4 -: KEY_W]; core_key3 = state[KEY_W-1:0]; all registered.
REQ-008 Valid tracking: CORE_LAT-deep shift register. A vector issued in cycle k is captured at the end of cycle k+CORE_LAT.
REQ-009 Capture: fold(core_out) = XOR of all DATA_W/SIG_W slices; signature_next = rotl1(signature) XOR fold.
REQ-010 done SHALL rise exactly NUM_VEC+CORE_LAT+1 rising edges after the edge that samples start; it holds with signature frozen until the next launch or reset.
REQ-011 busy=1 in RUN and DRAIN only; done=1 in DONE only.
REQ-012 start in RUN/DRAIN, and mode changes after launch, SHALL be ignored.
REQ-013 Outside RUN, core_in and keys hold their last values; no valid token is inserted.
REQ-014 Counters SHALL be sized clog2(NUM_VEC+1) bits and never wrap.

Reset
REQ-015 On reset, all outputs are 0, state is IDLE, LFSR/counters/valid pipe/signature are cleared.
REQ-016 Reset mid-RUN/DRAIN SHALL take effect on the next edge. Later core_out values SHALL NOT be captured.

Structure
REQ-017 Package crypto_harness_pkg SHALL hold the state enum, the LFSR tap constant and the 16'hACE1 default seed.
REQ-018 The signature register and fold logic SHALL be one sub-module, sig_misr, parametrised by DATA_W and SIG_W.

Verification
Bench core model: a CORE_LAT-cycle identity delay line. Reference model computes the expected signature.
REQ-019 Reset, then idle 10 cycles -> all outputs 0, busy=0, done=0.
REQ-020 seed=16'h1234, NUM_VEC=4, CORE_LAT=3, start pulse -> first core_in=64'h1234123412341234; done on edge 8 after start; signature equals model.
REQ-021 seed=0 -> first core_in=64'hACE1ACE1ACE1ACE1.
REQ-022 start held high whole run -> single run; relaunch from DONE clears signature, reproduces identical signature, core_decrypt follows mode latched at relaunch.
REQ-023 reset at RUN cycle 2 -> next cycle all outputs 0, IDLE; no capture from in-flight results; following run matches model.
REQ-024 mode=1 at launch, toggled mid-run -> core_decrypt stays 1 for the entire run.
